// File: rtl/cdb_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : cdb_wb_queue
// Description : In-order result queue between one functional unit and the CDB
//               arbiter. It holds the oldest result on out_* until granted.
//               Define CDB_WB_BYPASS_EN to let an empty queue forward in_*
//               straight to out_* in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_wb_queue #(
   parameter int DEPTH  = 4,
   parameter int ROB_W  = 4,
   parameter int DATA_W = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ROB_W-1:0]           in_rob_id,
   input  logic [DATA_W-1:0]          in_value,
   input  logic [DATA_W-1:0]          in_addr,
   input  logic                       in_branch_outcome,
   output logic                       out_valid,
   output logic [ROB_W-1:0]           out_rob_id,
   output logic [DATA_W-1:0]          out_value,
   output logic [DATA_W-1:0]          out_addr,
   output logic                       out_branch_outcome,
   input  logic                       grant,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int C_PTR_W = $clog2(DEPTH);
   localparam int C_CNT_W = $clog2(DEPTH + 1);
   localparam logic [C_CNT_W-1:0] C_FULL = C_CNT_W'(DEPTH);

   logic [ROB_W-1:0]   r_rob_mem    [DEPTH];
   logic [DATA_W-1:0]  r_value_mem  [DEPTH];
   logic [DATA_W-1:0]  r_addr_mem   [DEPTH];
   logic               r_branch_mem [DEPTH];

   logic [C_PTR_W-1:0] r_head;
   logic [C_PTR_W-1:0] r_tail;
   logic [C_CNT_W-1:0] r_count;

   logic w_stored;
   logic w_bypass;
   logic w_push;
   logic w_pop;

   assign w_stored = (r_count != '0);
   assign in_ready = (r_count != C_FULL);

`ifdef CDB_WB_BYPASS_EN
   assign w_bypass = !w_stored && in_valid && !flush;
`else
   assign w_bypass = 1'b0;
`endif

   assign out_valid = w_stored || w_bypass;
   assign w_pop     = grant && w_stored;
   // A bypassed result that is granted immediately never needs a slot.
   assign w_push    = in_valid && in_ready && !(w_bypass && grant);
   assign count     = r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + C_PTR_W'(1);
         end
         if (w_pop) begin
            r_head <= r_head + C_PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + C_CNT_W'(1);
            2'b01:   r_count <= r_count - C_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !flush) begin
         r_rob_mem[r_tail]    <= in_rob_id;
         r_value_mem[r_tail]  <= in_value;
         r_addr_mem[r_tail]   <= in_addr;
         r_branch_mem[r_tail] <= in_branch_outcome;
      end
   end

   always_comb begin
      out_rob_id         = '0;
      out_value          = '0;
      out_addr           = '0;
      out_branch_outcome = 1'b0;
      if (w_stored) begin
         out_rob_id         = r_rob_mem[r_head];
         out_value          = r_value_mem[r_head];
         out_addr           = r_addr_mem[r_head];
         out_branch_outcome = r_branch_mem[r_head];
      end else if (w_bypass) begin
         out_rob_id         = in_rob_id;
         out_value          = in_value;
         out_addr           = in_addr;
         out_branch_outcome = in_branch_outcome;
      end
   end

endmodule
`default_nettype wire
